// File: rtl/vol_ctrl_pkg.sv
// vol_ctrl_pkg: register offsets and CTRL/STAT bit positions for the volume ramp controller
package vol_ctrl_pkg;
  localparam int CTRL_MUTE    = 0;
  localparam int CTRL_RAMP_EN = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int STAT_DONE    = 0;
  localparam int STAT_BUSY    = 8;

  function automatic int ch_addr(input int k);
    return k;
  endfunction

  function automatic int ctrl_addr(input int num_ch);
    return num_ch;
  endfunction

  function automatic int stat_addr(input int num_ch);
    return num_ch + 1;
  endfunction
endpackage

// File: rtl/vol_ramp_channel.sv
// vol_ramp_channel: one volume word stepping one LSB per tick toward its effective target
module vol_ramp_channel #(
  parameter int VOL_W     = 7,
  parameter int RESET_VOL = 121
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             ramp_en,
  input  logic [VOL_W-1:0] eff_tgt,
  output logic [VOL_W-1:0] current,
  output logic             busy
);
  logic [VOL_W-1:0] nxt;

  // bypass tracks the target directly; otherwise step toward it on tick and saturate there
  always_comb
    nxt = !ramp_en ? eff_tgt :
          (!tick || current == eff_tgt) ? current :
          (current < eff_tgt) ? current + 1'b1 : current - 1'b1;

  // current volume register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) current <= VOL_W'(RESET_VOL);
    else current <= nxt;

  assign busy = current != eff_tgt;
endmodule

// File: rtl/avalon_vol_ramp_ctrl.sv
// avalon_vol_ramp_ctrl: Avalon-MM volume targets with click-free ramping, global mute and done interrupt
module avalon_vol_ramp_ctrl
  import vol_ctrl_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int VOL_W     = 7,
  parameter int RESET_VOL = 121,
  parameter int STEP_DIV  = 48000,
  parameter int ADDR_W    = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_W-1:0]       address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [NUM_CH*VOL_W-1:0] out_vol,
  output logic [NUM_CH-1:0]       ramp_busy,
  output logic                    irq
);
  localparam int PW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  localparam logic [ADDR_W-1:0] CTRL_A = ADDR_W'(ctrl_addr(NUM_CH));
  localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(stat_addr(NUM_CH));

  logic [PW-1:0]    cnt;
  logic             tick, wr, ctrl_wr, stat_clr, dp_nxt;
  logic             mute, ramp_en, irq_en, done_pend, any_busy_q;
  logic [VOL_W-1:0] target [NUM_CH];
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign tick      = cnt == PW'(STEP_DIV - 1);
  assign ctrl_wr   = wr && address == CTRL_A;
  assign stat_clr  = wr && address == STAT_A && writedata[STAT_DONE];
  assign dp_nxt    = (any_busy_q & ~|ramp_busy) | (done_pend & ~stat_clr);
  assign unused_wd = ^writedata;

  // free-running step prescaler, untouched by bus traffic
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;

  // per-channel target registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) for (int i = 0; i < NUM_CH; i++) target[i] <= VOL_W'(RESET_VOL);
    else for (int i = 0; i < NUM_CH; i++) if (wr && address == ADDR_W'(ch_addr(i))) target[i] <= writedata[VOL_W-1:0];

  // control bits, ramp-done latch and irq; irq uses next-state values so it tracks done_pend & irq_en without extra lag
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mute       <= 1'b0;
      ramp_en    <= 1'b1;
      irq_en     <= 1'b0;
      done_pend  <= 1'b0;
      any_busy_q <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        mute    <= writedata[CTRL_MUTE];
        ramp_en <= writedata[CTRL_RAMP_EN];
        irq_en  <= writedata[CTRL_IRQ_EN];
      end
      done_pend  <= dp_nxt;
      any_busy_q <= |ramp_busy;
      irq        <= dp_nxt & (ctrl_wr ? writedata[CTRL_IRQ_EN] : irq_en);
    end

  // zero-latency read mux
  always_comb begin
    readdata = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (address == ADDR_W'(ch_addr(i))) begin
        readdata[16+:VOL_W] = out_vol[i*VOL_W+:VOL_W];
        readdata[0+:VOL_W]  = target[i];
      end
    if (address == CTRL_A) begin
      readdata[CTRL_MUTE]    = mute;
      readdata[CTRL_RAMP_EN] = ramp_en;
      readdata[CTRL_IRQ_EN]  = irq_en;
    end
    if (address == STAT_A) begin
      readdata[STAT_DONE]          = done_pend;
      readdata[STAT_BUSY+:NUM_CH] = ramp_busy;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [VOL_W-1:0] eff;
    assign eff = mute ? '0 : target[k];
    vol_ramp_channel #(.VOL_W(VOL_W), .RESET_VOL(RESET_VOL)) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .ramp_en (ramp_en),
      .eff_tgt (eff),
      .current (out_vol[k*VOL_W+:VOL_W]),
      .busy    (ramp_busy[k])
    );
  end
endmodule

// File: tb/tb_avalon_vol_ramp_ctrl.sv
// tb_avalon_vol_ramp_ctrl: directed checks of ramping, mute, irq, bypass and edge cases
module tb_avalon_vol_ramp_ctrl;
  logic        clk, reset_n;
  logic [2:0]  address, a1;
  logic        chipselect, write_n, cs1, wn1;
  logic [31:0] writedata, readdata, wd1, rd1;
  logic [13:0] out_vol, ov1;
  logic [1:0]  ramp_busy, rb1;
  logic        irq, irq1;
  logic [31:0] cyc;
  logic [31:0] r;
  int          vectors = 0, errs = 0;

  avalon_vol_ramp_ctrl #(.NUM_CH(2), .VOL_W(7), .RESET_VOL(121), .STEP_DIV(4), .ADDR_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .out_vol(out_vol), .ramp_busy(ramp_busy), .irq(irq));

  avalon_vol_ramp_ctrl #(.NUM_CH(2), .VOL_W(7), .RESET_VOL(121), .STEP_DIV(1), .ADDR_W(3)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(a1), .chipselect(cs1), .write_n(wn1),
    .writedata(wd1), .readdata(rd1), .out_vol(ov1), .ramp_busy(rb1), .irq(irq1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // clocks since reset release; with STEP_DIV=4 a tick edge follows whenever cyc%4==3
  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic wr1(input logic [2:0] a, input logic [31:0] d);
    a1 = a; wd1 = d; cs1 = 1'b1; wn1 = 1'b0;
    @(negedge clk);
    cs1 = 1'b0; wn1 = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1 d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic align();
    while (cyc[1:0] != 2'd3) @(negedge clk);
  endtask

  task automatic wait_vol(input logic [13:0] exp, input int lim, input string tag);
    int n = 0;
    while (out_vol !== exp && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(out_vol), 32'(exp));
  endtask

  initial begin
    int nb, changes;
    logic [6:0] prev, maxv;
    reset_n = 1'b0;
    address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    a1 = '0; cs1 = 1'b0; wn1 = 1'b1; wd1 = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    chk("rst_out_vol", 32'(out_vol), 32'({7'd121, 7'd121}));
    chk("rst_busy", 32'(ramp_busy), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rd(3'd2, r); chk("rst_ctrl", r, 32'h2);
    rd(3'd0, r); chk("rst_ch0", r, 32'h0079_0079);
    rd(3'd3, r); chk("rst_stat", r, 32'h0);

    align();
    wr(3'd0, 32'd118);
    nb = 0;
    for (int j = 1; j <= 20; j++) begin
      if (ramp_busy[0]) nb++;
      if (j == 4) chk("ramp_hold121", 32'(out_vol[6:0]), 32'd121);
      if (j == 5) chk("ramp_120", 32'(out_vol[6:0]), 32'd120);
      if (j == 9) chk("ramp_119", 32'(out_vol[6:0]), 32'd119);
      if (j == 13) chk("ramp_118", 32'(out_vol[6:0]), 32'd118);
      if (j < 20) @(negedge clk);
    end
    chk("ramp_busy_cycles", 32'(nb), 32'd12);
    chk("ramp_final", 32'(out_vol), 32'({7'd121, 7'd118}));
    rd(3'd3, r); chk("ramp_stat_done", r, 32'h1);
    wr(3'd3, 32'h1);
    rd(3'd3, r); chk("ramp_stat_w1c", r, 32'h0);

    align();
    wr(3'd0, 32'd100);
    begin
      int n = 0;
      while (out_vol[6:0] !== 7'd115 && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    chk("rev_reach115", 32'(out_vol[6:0]), 32'd115);
    wr(3'd0, 32'd117);
    prev = out_vol[6:0]; maxv = prev; changes = 0;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      if (out_vol[6:0] != prev) changes++;
      if (out_vol[6:0] > maxv) maxv = out_vol[6:0];
      prev = out_vol[6:0];
    end
    chk("rev_changes", 32'(changes), 32'd2);
    chk("rev_no_overshoot", 32'(maxv), 32'd117);
    chk("rev_final", 32'(out_vol[6:0]), 32'd117);
    rd(3'd0, r); chk("rev_ch0_read", r, 32'h0075_0075);

    wr(3'd3, 32'h1);
    wr(3'd2, 32'h7);
    wait_vol(14'd0, 600, "mute_to_zero");
    chk("mute_irq_not_yet", 32'(irq), 32'd0);
    @(negedge clk);
    chk("mute_irq", 32'(irq), 32'd1);
    rd(3'd3, r); chk("mute_stat", r, 32'h1);
    rd(3'd0, r); chk("mute_tgt_kept", r, 32'h0000_0075);
    wr(3'd3, 32'h1);
    chk("w1c_irq_low", 32'(irq), 32'd0);
    rd(3'd3, r); chk("w1c_stat", r, 32'h0);
    wr(3'd2, 32'h6);
    wait_vol({7'd121, 7'd117}, 600, "unmute_restore");
    @(negedge clk);
    chk("unmute_irq", 32'(irq), 32'd1);
    wr(3'd2, 32'h2);
    chk("mask_irq", 32'(irq), 32'd0);
    rd(3'd3, r); chk("mask_pend_kept", r, 32'h1);
    wr(3'd3, 32'h1);

    wr(3'd2, 32'h0);
    wr(3'd1, 32'd5);
    chk("byp_ch1_pre", 32'(out_vol[13:7]), 32'd121);
    chk("byp_busy_pre", 32'(ramp_busy), 32'h2);
    @(negedge clk);
    chk("byp_ch1", 32'(out_vol[13:7]), 32'd5);
    chk("byp_busy_post", 32'(ramp_busy), 32'h0);
    rd(3'd1, r); chk("byp_ch1_read", r, 32'h0005_0005);
    rd(3'd2, r); chk("byp_ctrl", r, 32'h0);
    rd(3'd5, r); chk("unmapped_read", r, 32'h0);
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd0, r); chk("unmapped_wr_ch0", r, 32'h0075_0075);
    rd(3'd1, r); chk("unmapped_wr_ch1", r, 32'h0005_0005);

    wr1(3'd0, 32'd118);
    chk("edge_old_tgt", 32'(ov1[6:0]), 32'd121);
    @(negedge clk);
    chk("edge_step1", 32'(ov1[6:0]), 32'd120);
    @(negedge clk);
    chk("edge_step2", 32'(ov1[6:0]), 32'd119);
    wr1(3'd0, 32'd125);
    chk("edge_rev_old_dir", 32'(ov1[6:0]), 32'd118);
    @(negedge clk);
    chk("edge_rev_new_dir", 32'(ov1[6:0]), 32'd119);

    wr(3'd2, 32'h2);
    wr(3'd0, 32'd10);
    repeat (20) @(negedge clk);
    chk("midramp_busy", 32'(ramp_busy[0]), 32'd1);
    reset_n = 1'b0;
    address = 3'd1; writedata = 32'd3; chipselect = 1'b1; write_n = 1'b0;
    #1;
    chk("rst_mid_out_vol", 32'(out_vol), 32'({7'd121, 7'd121}));
    chk("rst_mid_busy", 32'(ramp_busy), 32'd0);
    chk("rst_mid_irq", 32'(irq), 32'd0);
    repeat (3) @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    reset_n = 1'b1;
    rd(3'd1, r); chk("rst_wr_ignored", r, 32'h0079_0079);
    rd(3'd2, r); chk("rst_mid_ctrl", r, 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
